voq_req_gen: RTL and testbench

VOQ_REQ_GEN -- requirements
Module: voq_req_gen

---
 rtl/pslip_pkg.sv | 21 ++
 rtl/voq_req_gen_if.sv | 38 +++
 rtl/voq_counter.sv | 35 +++
 rtl/voq_req_gen.sv | 177 +++++++++++++++++
 tb/tb_voq_req_gen.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pslip_pkg.sv
// Shared defaults, FSM state type and a small helper for the VOQ request generator.
package pslip_pkg;

    localparam int N_DEF   = 4;
    localparam int P_DEF   = 16;
    localparam int D_DEF   = 8;
    localparam int TMO_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DEQ  = 2'd3
    } state_t;

    // True when no more than one bit of v is set.
    function automatic logic at_most_one(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/voq_req_gen_if.sv
// Arrival, scheduler and crossbar signals of the VOQ request generator.
interface voq_req_gen_if
    import pslip_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int P = P_DEF
);
    localparam int DW = (N > 1) ? $clog2(N) : 1;
    localparam int C  = (P > 1) ? $clog2(P) : 1;

    logic [N-1:0]                 arr_valid;
    logic [N-1:0][DW-1:0]         arr_dest;
    logic [N-1:0]                 arr_ready;
    logic                         start;
    logic [N-1:0][N-1:0][C-1:0]   pri_req_out;
    logic [N-1:0][N-1:0]          decision;
    logic                         decision_ready;
    logic [N-1:0][N-1:0]          xbar_cfg;
    logic                         xbar_valid;
    logic                         busy;
    logic                         err_conflict;
    logic                         err_timeout;

    // Traffic source / scheduler side.
    modport master (
        output arr_valid, arr_dest, decision, decision_ready,
        input  arr_ready, start, pri_req_out, xbar_cfg, xbar_valid,
               busy, err_conflict, err_timeout
    );

    // Request generator side.
    modport slave (
        input  arr_valid, arr_dest, decision, decision_ready,
        output arr_ready, start, pri_req_out, xbar_cfg, xbar_valid,
               busy, err_conflict, err_timeout
    );

endinterface

// File: rtl/voq_counter.sv
// Occupancy counter of one VOQ: saturating at D, never below 0.
module voq_counter
    import pslip_pkg::*;
#(
    parameter int D = D_DEF,
    parameter int W = $clog2(D + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full
);
    logic [W-1:0] cnt_q, cnt_d;

    // Simultaneous inc and dec cancel; the guards stop wrap at either end.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && cnt_q != W'(D))
            cnt_d = cnt_q + W'(1);
        else if (dec && !inc && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q == W'(D));

endmodule

// File: rtl/voq_req_gen.sv
// VOQ request generator: counts cells per (input, output) pair, offers a
// weight snapshot to an external scheduler each round and applies its matching.
module voq_req_gen
    import pslip_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int P   = P_DEF,
    parameter int D   = D_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic         clk,
    input  logic         reset,
    voq_req_gen_if.slave bus
);
    localparam int C  = (P > 1) ? $clog2(P) : 1;
    localparam int W  = $clog2(D + 1);
    localparam int DW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [C-1:0] WMAX = C'(P - 1);

    logic [N-1:0][N-1:0][W-1:0] occ;
    logic [N-1:0][N-1:0]        full, inc, dec;
    logic [N-1:0]               rdy;
    logic [N-1:0][N-1:0][C-1:0] weight;
    logic                       any_occ;
    logic                       dec_ok;
    logic                       deq_en;

    state_t                     state_q, state_d;
    logic [N-1:0][N-1:0][C-1:0] pri_q, pri_d;
    logic [N-1:0][N-1:0]        dcap_q, dcap_d;
    logic [N-1:0][N-1:0]        xcfg_q, xcfg_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic                       start_q, start_d;
    logic                       xv_q, xv_d;
    logic                       errc_q, errc_d;
    logic                       errt_q, errt_d;

    // Arrival acceptance from the current count only, and per-VOQ inc/dec strobes.
    always_comb begin
        rdy = '0;
        inc = '0;
        dec = '0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = !full[i][bus.arr_dest[i]];
            for (int j = 0; j < N; j++) begin
                inc[i][j] = bus.arr_valid[i] && rdy[i] && (bus.arr_dest[i] == DW'(j));
                dec[i][j] = deq_en && dcap_q[i][j];
            end
        end
    end

    // Request weights clipped to the top priority level; any nonzero VOQ opens a round.
    always_comb begin
        weight  = '0;
        any_occ = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (int'(occ[i][j]) > P - 1) weight[i][j] = WMAX;
                else                         weight[i][j] = C'(occ[i][j]);
                if (occ[i][j] != '0) any_occ = 1'b1;
            end
        end
    end

    // A captured matching is usable only if it is a partial permutation over requested pairs.
    always_comb begin
        logic [N-1:0] col;
        dec_ok = 1'b1;
        col    = '0;
        for (int i = 0; i < N; i++) begin
            if (!at_most_one(32'(dcap_q[i]))) dec_ok = 1'b0;
        end
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                col[i] = dcap_q[i][j];
                if (dcap_q[i][j] && pri_q[i][j] == '0) dec_ok = 1'b0;
            end
            if (!at_most_one(32'(col))) dec_ok = 1'b0;
        end
    end

    // Round sequencing: snapshot, wait for the scheduler, then dequeue or flag.
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        dcap_d  = dcap_q;
        xcfg_d  = xcfg_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
        xv_d    = 1'b0;
        errc_d  = errc_q;
        errt_d  = errt_q;
        deq_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_occ) state_d = ST_REQ;
            end
            ST_REQ: begin
                pri_d   = weight;
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.decision_ready) begin
                    dcap_d  = bus.decision;
                    state_d = ST_DEQ;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    errt_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DEQ: begin
                if (dec_ok) begin
                    deq_en = 1'b1;
                    xcfg_d = dcap_q;
                    xv_d   = 1'b1;
                end else begin
                    errc_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and output registers; reset drops any in-flight decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pri_q   <= '0;
            dcap_q  <= '0;
            xcfg_q  <= '0;
            tmo_q   <= '0;
            start_q <= 1'b0;
            xv_q    <= 1'b0;
            errc_q  <= 1'b0;
            errt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            dcap_q  <= dcap_d;
            xcfg_q  <= xcfg_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            xv_q    <= xv_d;
            errc_q  <= errc_d;
            errt_q  <= errt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            voq_counter #(.D(D), .W(W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc[i][j]),
                .dec   (dec[i][j]),
                .cnt   (occ[i][j]),
                .full  (full[i][j])
            );
        end
    end

    assign bus.arr_ready    = rdy;
    assign bus.start        = start_q;
    assign bus.pri_req_out  = pri_q;
    assign bus.xbar_cfg     = xcfg_q;
    assign bus.xbar_valid   = xv_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.err_conflict = errc_q;
    assign bus.err_timeout  = errt_q;

endmodule

// File: tb/tb_voq_req_gen.sv
// Bench for voq_req_gen: directed rounds, a vector table for the fill boundary,
// and randomized rounds against an occupancy-array reference model.
module tb_voq_req_gen;
    localparam int N = 4, P = 16, D = 8, TMO = 64, C = 4, DW = 2;

    typedef logic [N-1:0][N-1:0]         dmat_t;
    typedef logic [N-1:0][N-1:0][C-1:0]  pmat_t;
    typedef logic [N-1:0][DW-1:0]        dest_t;
    typedef struct {
        logic [N-1:0] av;
        dest_t        ad;
        logic [N-1:0] exp_rdy;
    } vec_t;

    logic clk, reset;
    int   n_vec = 0, n_err = 0;

    int    m_occ[N][N];
    pmat_t snap;
    bit    saw_start, m_errc;
    int    cyc, last_start;

    voq_req_gen_if #(.N(N), .P(P)) bus ();
    voq_req_gen #(.N(N), .P(P), .D(D), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.arr_valid      = '0;
        bus.arr_dest       = '0;
        bus.decision       = '0;
        bus.decision_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_start(input int bound, input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            tick();
            if (bus.start) seen = 1'b1;
        end
        chk(nm, 64'(seen), 64'd1);
    endtask

    function automatic pmat_t weights_of(input int o[N][N]);
        pmat_t w = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                w[i][j] = C'((o[i][j] > P - 1) ? P - 1 : o[i][j]);
        return w;
    endfunction

    function automatic bit model_valid(input dmat_t d, input pmat_t s);
        int cnt;
        for (int i = 0; i < N; i++) begin
            cnt = 0;
            for (int j = 0; j < N; j++) cnt += int'(d[i][j]);
            if (cnt > 1) return 1'b0;
        end
        for (int j = 0; j < N; j++) begin
            cnt = 0;
            for (int i = 0; i < N; i++) cnt += int'(d[i][j]);
            if (cnt > 1) return 1'b0;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (d[i][j] && s[i][j] == '0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic dmat_t gen_match(input pmat_t s);
        dmat_t        d    = '0;
        logic [N-1:0] used = '0;
        int           j0, j;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                j0 = int'($urandom_range(0, N - 1));
                for (int t = 0; t < N; t++) begin
                    j = (j0 + t) % N;
                    if (s[i][j] != '0 && !used[j]) begin
                        d[i][j] = 1'b1;
                        used[j] = 1'b1;
                        break;
                    end
                end
            end
        end
        return d;
    endfunction

    // One cycle of randomized arrivals with model update; do_deq applies grant g at this edge.
    task automatic rstep(input bit dr, input dmat_t d, input bit do_deq, input dmat_t g);
        logic [N-1:0] av, er;
        dest_t        ad;
        int           pre[N][N];
        for (int i = 0; i < N; i++) begin
            av[i] = ($urandom_range(0, 99) < 28);
            ad[i] = DW'($urandom_range(0, N - 1));
        end
        bus.arr_valid      = av;
        bus.arr_dest       = ad;
        bus.decision_ready = dr;
        bus.decision       = d;
        #1;
        for (int i = 0; i < N; i++) er[i] = (m_occ[i][ad[i]] < D);
        chk("rnd_arr_ready", 64'(bus.arr_ready), 64'(er));
        pre = m_occ;
        @(posedge clk);
        #2;
        cyc++;
        for (int i = 0; i < N; i++)
            if (av[i] && er[i]) m_occ[i][ad[i]]++;
        if (do_deq)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (g[i][j]) m_occ[i][j]--;
        if (bus.start) begin
            saw_start = 1'b1;
            snap = weights_of(pre);
            chk("rnd_snapshot", 64'(bus.pri_req_out), 64'(snap));
            chk("rnd_start_gap", 64'(cyc - last_start >= 4), 64'd1);
            last_start = cyc;
        end
    endtask

    initial begin
        vec_t  tbl[11];
        pmat_t ep;
        dmat_t dm;
        int    nstart;

        reset = 1'b1;
        idle_in();

        // Reset state.
        do_reset();
        chk("rst_pri", 64'(bus.pri_req_out), 64'd0);
        chk("rst_start", 64'(bus.start), 64'd0);
        chk("rst_xcfg", 64'(bus.xbar_cfg), 64'd0);
        chk("rst_xvalid", 64'(bus.xbar_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_errs", 64'({bus.err_conflict, bus.err_timeout}), 64'd0);
        chk("rst_ready", 64'(bus.arr_ready), 64'hF);

        // Snapshot isolation and a single dequeue on VOQ[0][2].
        do_reset();
        bus.arr_valid = 4'b1000;
        tick();
        idle_in();
        wait_start(8, "t1_start0");
        ep = '0; ep[3][0] = 4'd1;
        chk("t1_snap0", 64'(bus.pri_req_out), 64'(ep));
        for (int k = 0; k < 3; k++) begin
            bus.arr_valid = 4'b0001;
            bus.arr_dest[0] = 2'd2;
            #1;
            chk("t1_rdy", 64'(bus.arr_ready[0]), 64'd1);
            tick();
        end
        idle_in();
        chk("t1_busy_wait", 64'(bus.busy), 64'd1);
        chk("t1_pri_stable", 64'(bus.pri_req_out), 64'(ep));
        bus.decision_ready = 1'b1;
        tick();
        bus.decision_ready = 1'b0;
        tick();
        chk("t1_xv_empty", 64'(bus.xbar_valid), 64'd1);
        chk("t1_xcfg_empty", 64'(bus.xbar_cfg), 64'd0);
        wait_start(8, "t1_start1");
        ep[0][2] = 4'd3;
        chk("t1_snap1", 64'(bus.pri_req_out), 64'(ep));
        dm = '0; dm[0][2] = 1'b1;
        bus.decision = dm;
        bus.decision_ready = 1'b1;
        tick();
        chk("t1_start_pulse", 64'(bus.start), 64'd0);
        bus.decision_ready = 1'b0;
        tick();
        chk("t1_xv", 64'(bus.xbar_valid), 64'd1);
        chk("t1_xcfg", 64'(bus.xbar_cfg), 64'(dm));
        tick();
        chk("t1_xv_pulse", 64'(bus.xbar_valid), 64'd0);
        idle_in();
        wait_start(8, "t1_start2");
        ep[0][2] = 4'd2;
        chk("t1_snap2", 64'(bus.pri_req_out), 64'(ep));

        // Fill VOQ[1][1] to D: vector table with expected arr_ready.
        for (int k = 0; k < 9; k++) begin
            tbl[k].av      = (k % 3 == 0) ? 4'b0110 : 4'b0010;
            tbl[k].ad      = '0;
            tbl[k].ad[1]   = 2'd1;
            tbl[k].ad[2]   = 2'd3;
            tbl[k].exp_rdy = (k < 8) ? 4'hF : 4'hD;
        end
        tbl[9].av = 4'b0000; tbl[9].ad = '0; tbl[9].ad[1] = 2'd1; tbl[9].exp_rdy = 4'hD;
        tbl[10].av = 4'b0000; tbl[10].ad = '0; tbl[10].exp_rdy = 4'hF;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            bus.arr_valid = tbl[k].av;
            bus.arr_dest  = tbl[k].ad;
            #1;
            chk($sformatf("tbl_rdy[%0d]", k), 64'(bus.arr_ready), 64'(tbl[k].exp_rdy));
            tick();
        end
        idle_in();
        bus.decision_ready = 1'b1;
        tick();
        bus.decision_ready = 1'b0;
        tick();
        chk("t2_xv_empty", 64'(bus.xbar_valid), 64'd1);
        wait_start(8, "t2_start_full");
        ep = '0; ep[1][1] = 4'd8; ep[2][3] = 4'd3;
        chk("t2_snap_full", 64'(bus.pri_req_out), 64'(ep));
        // Arrival held against a full VOQ while it is dequeued.
        dm = '0; dm[1][1] = 1'b1;
        bus.arr_valid = 4'b0010;
        bus.arr_dest[1] = 2'd1;
        bus.decision = dm;
        bus.decision_ready = 1'b1;
        #1;
        chk("t2_rdy_full_cap", 64'(bus.arr_ready[1]), 64'd0);
        tick();
        bus.decision_ready = 1'b0;
        #1;
        chk("t2_rdy_full_deq", 64'(bus.arr_ready[1]), 64'd0);
        tick();
        chk("t2_xv", 64'(bus.xbar_valid), 64'd1);
        chk("t2_xcfg", 64'(bus.xbar_cfg), 64'(dm));
        chk("t2_rdy_after_deq", 64'(bus.arr_ready[1]), 64'd1);
        tick();
        idle_in();
        wait_start(8, "t2_start_refill");
        chk("t2_snap_refill", 64'(bus.pri_req_out), 64'(ep));

        // Column conflict: rows 0 and 1 both granted output 3.
        do_reset();
        bus.arr_valid = 4'b0011;
        bus.arr_dest[0] = 2'd3;
        bus.arr_dest[1] = 2'd3;
        tick();
        idle_in();
        wait_start(8, "t3_start");
        ep = '0; ep[0][3] = 4'd1; ep[1][3] = 4'd1;
        chk("t3_snap", 64'(bus.pri_req_out), 64'(ep));
        dm = '0; dm[0][3] = 1'b1; dm[1][3] = 1'b1;
        bus.decision = dm;
        bus.decision_ready = 1'b1;
        tick();
        bus.decision_ready = 1'b0;
        tick();
        chk("t3_xv", 64'(bus.xbar_valid), 64'd0);
        chk("t3_errc", 64'(bus.err_conflict), 64'd1);
        chk("t3_busy", 64'(bus.busy), 64'd0);
        wait_start(8, "t3_start2");
        chk("t3_snap_kept", 64'(bus.pri_req_out), 64'(ep));
        chk("t3_errc_sticky", 64'(bus.err_conflict), 64'd1);

        // Scheduler never answers.
        do_reset();
        bus.arr_valid = 4'b0100;
        tick();
        idle_in();
        wait_start(8, "t4_start");
        repeat (TMO - 1) tick();
        chk("t4_busy_pre", 64'(bus.busy), 64'd1);
        chk("t4_errt_pre", 64'(bus.err_timeout), 64'd0);
        tick();
        chk("t4_errt", 64'(bus.err_timeout), 64'd1);
        chk("t4_idle", 64'(bus.busy), 64'd0);
        chk("t4_no_xv", 64'(bus.xbar_valid), 64'd0);
        wait_start(5, "t4_restart");
        ep = '0; ep[2][0] = 4'd1;
        chk("t4_snap", 64'(bus.pri_req_out), 64'(ep));

        // Reset mid-round, then a late decision.
        do_reset();
        bus.arr_valid = 4'b0001;
        bus.arr_dest[0] = 2'd1;
        tick();
        idle_in();
        wait_start(8, "t5_start");
        reset = 1'b1;
        tick();
        chk("t5_pri", 64'(bus.pri_req_out), 64'd0);
        chk("t5_start", 64'(bus.start), 64'd0);
        chk("t5_busy", 64'(bus.busy), 64'd0);
        chk("t5_xbar", 64'({bus.xbar_valid, bus.xbar_cfg}), 64'd0);
        chk("t5_errs", 64'({bus.err_conflict, bus.err_timeout}), 64'd0);
        reset = 1'b0;
        dm = '0; dm[0][1] = 1'b1;
        bus.decision = dm;
        bus.decision_ready = 1'b1;
        nstart = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.start || bus.xbar_valid || bus.busy) nstart++;
        end
        idle_in();
        chk("t5_late_ignored", 64'(nstart), 64'd0);
        chk("t5_errc", 64'(bus.err_conflict), 64'd0);

        // Randomized rounds against the occupancy model.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m_occ[i][j] = 0;
        m_errc = 1'b0;
        cyc = 0;
        last_start = -100;
        snap = '0;
        for (int r = 0; r < 60; r++) begin
            int    k;
            bit    v;
            int    dly;
            saw_start = 1'b0;
            k = 0;
            while (!saw_start && k < 30) begin
                rstep(1'b0, '0, 1'b0, '0);
                k++;
            end
            chk("rnd_start_seen", 64'(saw_start), 64'd1);
            dly = int'($urandom_range(0, 3));
            for (int t = 0; t < dly; t++) rstep(1'b0, '0, 1'b0, '0);
            dm = gen_match(snap);
            if ($urandom_range(0, 4) == 0)
                dm[$urandom_range(0, N - 1)][$urandom_range(0, N - 1)] = 1'b1;
            v = model_valid(dm, snap);
            if (!v) m_errc = 1'b1;
            rstep(1'b1, dm, 1'b0, '0);
            rstep(1'b0, '0, v, dm);
            chk("rnd_xv", 64'(bus.xbar_valid), 64'(v));
            if (v) chk("rnd_xcfg", 64'(bus.xbar_cfg), 64'(dm));
            chk("rnd_errc", 64'(bus.err_conflict), 64'(m_errc));
            chk("rnd_busy_idle", 64'(bus.busy), 64'd0);
            chk("rnd_errt", 64'(bus.err_timeout), 64'd0);
        end
        idle_in();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
